// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel position, blank/sync levels, line/frame strobes
// and the frame counter. The timing generator drives it (master); sprite
// readers and the video output stage consume it (slave).
interface vga_timing_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_cnt
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source (default 640x480@60 on 25 MHz vga_clk).
// Horizontal and vertical counters with region FSMs, registered sync/blank,
// line/frame strobes and an 8-bit frame counter.
// Optional macro VGA_SYNC_DELAY_EN: hs, vs and blank get one extra register
// stage so they line up with sprite colour that is registered after addressing.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic         vga_clk,
  input  logic         reset_n,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries all sit below TOTAL (<= 1024), so 10 bits hold them.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_B_FP   = 10'(H_ACTIVE);
  localparam logic [9:0] H_B_SYNC = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_B_BP   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_B_FP   = 10'(V_ACTIVE);
  localparam logic [9:0] V_B_SYNC = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_B_BP   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_FRONT,
    ST_SYNC,
    ST_BACK
  } region_e;

  // Region transition: enter a region exactly when the count hits its start.
  function automatic region_e next_region(
    input region_e    cur,
    input logic [9:0] cnt,
    input logic [9:0] b_fp,
    input logic [9:0] b_sync,
    input logic [9:0] b_bp
  );
    region_e nxt;
    nxt = cur;
    if (cnt == 10'd0)        nxt = ST_ACTIVE;
    else if (cnt == b_fp)    nxt = ST_FRONT;
    else if (cnt == b_sync)  nxt = ST_SYNC;
    else if (cnt == b_bp)    nxt = ST_BACK;
    return nxt;
  endfunction

  logic       run_q, run_d;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  region_e    h_st_q, h_st_d;
  region_e    v_st_q, v_st_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Next-state counters, regions and outputs; outputs describe the pixel at hc_d/vc_d.
  always_comb begin
    run_d       = 1'b1;
    hc_d        = hc_q;
    vc_d        = vc_q;
    frame_cnt_d = frame_cnt_q;
    if (!run_q) begin
      // First edge out of reset presents pixel (0,0) rather than advancing.
      hc_d = 10'd0;
      vc_d = 10'd0;
    end else if (hc_q == H_LAST) begin
      hc_d = 10'd0;
      if (vc_q == V_LAST) begin
        vc_d        = 10'd0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end else begin
      hc_d = hc_q + 10'd1;
    end

    h_st_d = next_region(h_st_q, hc_d, H_B_FP, H_B_SYNC, H_B_BP);
    v_st_d = next_region(v_st_q, vc_d, V_B_FP, V_B_SYNC, V_B_BP);

    blank_d       = (h_st_d == ST_ACTIVE) && (v_st_d == ST_ACTIVE);
    hs_d          = (h_st_d == ST_SYNC) ? HS_ON : ~HS_ON;
    vs_d          = (v_st_d == ST_SYNC) ? VS_ON : ~VS_ON;
    line_start_d  = (hc_d == 10'd0);
    frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);
  end

  // Counter/FSM/output registers; reset wins over everything, mid-frame included.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      h_st_q        <= ST_ACTIVE;
      v_st_q        <= ST_ACTIVE;
      blank_q       <= 1'b0;
      hs_q          <= ~HS_ON;
      vs_q          <= ~VS_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      run_q         <= run_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      h_st_q        <= h_st_d;
      v_st_q        <= v_st_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga.DrawX       = hc_q;
  assign vga.DrawY       = vc_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

`ifdef VGA_SYNC_DELAY_EN
  logic blank_dly_q;
  logic hs_dly_q;
  logic vs_dly_q;

  // One-cycle delay of sync/blank to match colour registered after addressing.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      blank_dly_q <= 1'b0;
      hs_dly_q    <= ~HS_ON;
      vs_dly_q    <= ~VS_ON;
    end else begin
      blank_dly_q <= blank_q;
      hs_dly_q    <= hs_q;
      vs_dly_q    <= vs_q;
    end
  end

  assign vga.blank = blank_dly_q;
  assign vga.hs    = hs_dly_q;
  assign vga.vs    = vs_dly_q;
`else
  assign vga.blank = blank_q;
  assign vga.hs    = hs_q;
  assign vga.vs    = vs_q;
`endif

endmodule
